// File: rtl/bf_pkg.sv
// Shared definitions for the Bellman-Ford engine: widths, lane-word layout, FSM states.
package bf_pkg;

    localparam int unsigned NODES  = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DIST_W = 7;
    localparam int unsigned EW_W   = 4;
    localparam int unsigned LANE_W = 22;

    // Update-word field positions
    localparam int unsigned UPD_BIT = 21;
    localparam int unsigned WIJ_MSB = 20;
    localparam int unsigned WIJ_LSB = 17;
    localparam int unsigned I_MSB   = 16;
    localparam int unsigned I_LSB   = 12;
    localparam int unsigned J_MSB   = 11;
    localparam int unsigned J_LSB   = 7;
    localparam int unsigned WI_MSB  = 6;
    localparam int unsigned WI_LSB  = 0;

    localparam logic [DIST_W-1:0] DIST_INF = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bf_state_e;

endpackage

// File: rtl/bf_relax_lane.sv
// One relaxation lane: saturated candidate distance and improve-or-not decision.
module bf_relax_lane
    import bf_pkg::*;
(
    input  logic [LANE_W-1:0] lane_word,
    input  logic [DIST_W-1:0] cur_dist,
    output logic [DIST_W-1:0] cand_c,
    output logic              commit_c,
    output logic [IDX_W-1:0]  i_c,
    output logic [IDX_W-1:0]  j_c
);

    logic              upd;
    logic [EW_W-1:0]   wij;
    logic [DIST_W-1:0] wi;
    logic [DIST_W:0]   sum;

    // Decode the word, form the 8-bit sum, clamp to INF, and compare strictly
    always_comb begin
        upd      = lane_word[UPD_BIT];
        wij      = lane_word[WIJ_MSB:WIJ_LSB];
        i_c      = lane_word[I_MSB:I_LSB];
        j_c      = lane_word[J_MSB:J_LSB];
        wi       = lane_word[WI_MSB:WI_LSB];
        sum      = (DIST_W+1)'(wi) + (DIST_W+1)'(wij);
        cand_c   = sum[DIST_W] ? DIST_INF : sum[DIST_W-1:0];
        commit_c = upd && (wi != DIST_INF) && (cand_c < cur_dist);
    end

endmodule

// File: rtl/bf_relax_stage.sv
// Relaxation/commit stage: S1 beat register, S2 four-lane compare/commit, pass tracking.
module bf_relax_stage
    import bf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IDX_W-1:0]    src_idx,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [LANE_W-1:0]   lane_a,
    input  logic [LANE_W-1:0]   lane_b,
    input  logic [LANE_W-1:0]   lane_c,
    input  logic [LANE_W-1:0]   lane_d,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DIST_W-1:0]   rd_dist,
    output logic [IDX_W-1:0]    rd_pred,
    output logic                pass_done,
    output logic                pass_changed,
    output logic [IDX_W-1:0]    pass_count,
    output logic                converged
);

    bf_state_e          state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               converged_q, converged_d;
    logic               pass_done_q, pass_done_d;
    logic               pass_changed_q, pass_changed_d;
    logic               changed_q, changed_d;
    logic [IDX_W-1:0]   pass_count_q, pass_count_d;
    logic [DIST_W-1:0]  dist_q [NODES];
    logic [DIST_W-1:0]  dist_d [NODES];
    logic [IDX_W-1:0]   pred_q [NODES];
    logic [IDX_W-1:0]   pred_d [NODES];
    logic               s1_valid_q, s1_valid_d;
    logic               s1_last_q, s1_last_d;
    logic [LANE_W-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d, s1_d_q, s1_d_d;

    logic               accept;
    logic [DIST_W-1:0]  cur_a, cur_b, cur_c, cur_d;
    logic [DIST_W-1:0]  cand_a, cand_b, cand_c, cand_d;
    logic               commit_a, commit_b, commit_c, commit_d;
    logic [IDX_W-1:0]   i_a, i_b, i_c, i_d, j_a, j_b, j_c, j_d;
    logic               wr_a, wr_b, wr_c, wr_d, any_wr;
    logic [IDX_W-1:0]   pass_inc;

    assign accept = in_valid & in_ready_q;

    // Each lane sees the distance left by earlier committing lanes with the same j
    assign cur_a = dist_q[j_a];
    assign cur_b = (commit_a && (j_a == j_b)) ? cand_a : dist_q[j_b];
    assign cur_c = (commit_b && (j_b == j_c)) ? cand_b :
                   (commit_a && (j_a == j_c)) ? cand_a : dist_q[j_c];
    assign cur_d = (commit_c && (j_c == j_d)) ? cand_c :
                   (commit_b && (j_b == j_d)) ? cand_b :
                   (commit_a && (j_a == j_d)) ? cand_a : dist_q[j_d];

    bf_relax_lane u_lane_a (.lane_word(s1_a_q), .cur_dist(cur_a), .cand_c(cand_a), .commit_c(commit_a), .i_c(i_a), .j_c(j_a));
    bf_relax_lane u_lane_b (.lane_word(s1_b_q), .cur_dist(cur_b), .cand_c(cand_b), .commit_c(commit_b), .i_c(i_b), .j_c(j_b));
    bf_relax_lane u_lane_c (.lane_word(s1_c_q), .cur_dist(cur_c), .cand_c(cand_c), .commit_c(commit_c), .i_c(i_c), .j_c(j_c));
    bf_relax_lane u_lane_d (.lane_word(s1_d_q), .cur_dist(cur_d), .cand_c(cand_d), .commit_c(commit_d), .i_c(i_d), .j_c(j_d));

    assign wr_a     = s1_valid_q & commit_a;
    assign wr_b     = s1_valid_q & commit_b;
    assign wr_c     = s1_valid_q & commit_c;
    assign wr_d     = s1_valid_q & commit_d;
    assign any_wr   = wr_a | wr_b | wr_c | wr_d;
    assign pass_inc = pass_count_q + IDX_W'(1);

    // Next-state: start re-initialisation wins over the S2 commit and pass bookkeeping
    always_comb begin
        state_d        = state_q;
        pass_count_d   = pass_count_q;
        changed_d      = changed_q;
        pass_done_d    = 1'b0;
        pass_changed_d = pass_changed_q;
        dist_d         = dist_q;
        pred_d         = pred_q;
        s1_valid_d     = accept;
        s1_last_d      = accept ? in_last : s1_last_q;
        s1_a_d         = accept ? lane_a : s1_a_q;
        s1_b_d         = accept ? lane_b : s1_b_q;
        s1_c_d         = accept ? lane_c : s1_c_q;
        s1_d_d         = accept ? lane_d : s1_d_q;

        if (start) begin
            for (int unsigned n = 0; n < NODES; n++) begin
                dist_d[IDX_W'(n)] = DIST_INF;
            end
            dist_d[src_idx] = '0;
            pred_d[src_idx] = src_idx;
            pass_count_d    = '0;
            changed_d       = 1'b0;
            pass_changed_d  = 1'b0;
            s1_valid_d      = 1'b0;
            state_d         = ST_RUN;
        end else if (s1_valid_q) begin
            if (wr_a) begin dist_d[j_a] = cand_a; pred_d[j_a] = i_a; end
            if (wr_b) begin dist_d[j_b] = cand_b; pred_d[j_b] = i_b; end
            if (wr_c) begin dist_d[j_c] = cand_c; pred_d[j_c] = i_c; end
            if (wr_d) begin dist_d[j_d] = cand_d; pred_d[j_d] = i_d; end
            if (s1_last_q && (state_q == ST_RUN)) begin
                pass_done_d    = 1'b1;
                pass_changed_d = changed_q | any_wr;
                pass_count_d   = pass_inc;
                changed_d      = 1'b0;
                if (!(changed_q | any_wr) || (pass_inc == IDX_W'(NODES - 1))) begin
                    state_d = ST_DONE;
                end
            end else begin
                changed_d = changed_q | any_wr;
            end
        end

        in_ready_d  = (state_d == ST_RUN);
        converged_d = (state_d == ST_DONE);
    end

    // State, tables and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            in_ready_q     <= 1'b0;
            converged_q    <= 1'b0;
            pass_done_q    <= 1'b0;
            pass_changed_q <= 1'b0;
            changed_q      <= 1'b0;
            pass_count_q   <= '0;
            for (int unsigned n = 0; n < NODES; n++) begin
                dist_q[IDX_W'(n)] <= DIST_INF;
                pred_q[IDX_W'(n)] <= '0;
            end
            s1_valid_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_c_q         <= '0;
            s1_d_q         <= '0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            converged_q    <= converged_d;
            pass_done_q    <= pass_done_d;
            pass_changed_q <= pass_changed_d;
            changed_q      <= changed_d;
            pass_count_q   <= pass_count_d;
            dist_q         <= dist_d;
            pred_q         <= pred_d;
            s1_valid_q     <= s1_valid_d;
            s1_last_q      <= s1_last_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_c_q         <= s1_c_d;
            s1_d_q         <= s1_d_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign converged    = converged_q;
    assign pass_done    = pass_done_q;
    assign pass_changed = pass_changed_q;
    assign pass_count   = pass_count_q;
    assign rd_dist      = dist_q[rd_idx];
    assign rd_pred      = pred_q[rd_idx];

endmodule

// File: tb/tb_bf_relax_stage.sv
// Bench for bf_relax_stage: directed scenarios plus randomized passes against a table model.
module tb_bf_relax_stage;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last;
    logic [4:0]  src_idx, rd_idx;
    logic [21:0] lane_a, lane_b, lane_c, lane_d;
    logic        in_ready, pass_done, pass_changed, converged;
    logic [6:0]  rd_dist;
    logic [4:0]  rd_pred, pass_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [6:0] m_dist [32];
    logic [4:0] m_pred [32];
    bit         m_run, m_done, m_changed;
    int         m_count;
    bit         e_done, e_chg;

    bf_relax_stage dut (
        .clk(clk), .rst(rst), .start(start), .src_idx(src_idx),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .lane_a(lane_a), .lane_b(lane_b), .lane_c(lane_c), .lane_d(lane_d),
        .rd_idx(rd_idx), .rd_dist(rd_dist), .rd_pred(rd_pred),
        .pass_done(pass_done), .pass_changed(pass_changed),
        .pass_count(pass_count), .converged(converged)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] mk(input bit u, input int w, input int i, input int j, input int wi);
        return {u, 4'(w), 5'(i), 5'(j), 7'(wi)};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 32; n++) begin m_dist[n] = 7'h7F; m_pred[n] = 5'd0; end
        m_run = 0; m_done = 0; m_changed = 0; m_count = 0; e_done = 0; e_chg = 0;
    endtask

    task automatic model_start(input int src);
        for (int n = 0; n < 32; n++) m_dist[n] = 7'h7F;
        m_dist[src] = 7'd0;
        m_pred[src] = 5'(src);
        m_run = 1; m_done = 0; m_changed = 0; m_count = 0;
    endtask

    // Lanes applied strictly in order A..D, each against the table left by earlier ones
    task automatic model_beat(input logic [21:0] a, b, c, d, input bit last);
        logic [21:0] ln [4];
        bit any;
        int cand, wi, w, i, j;
        e_done = 0;
        if (!m_run) return;
        ln = '{a, b, c, d};
        any = 0;
        for (int k = 0; k < 4; k++) begin
            wi = int'(ln[k][6:0]);
            w  = int'(ln[k][20:17]);
            i  = int'(ln[k][16:12]);
            j  = int'(ln[k][11:7]);
            if (ln[k][21] && wi != 127) begin
                cand = wi + w;
                if (cand > 127) cand = 127;
                if (cand < int'(m_dist[j])) begin
                    m_dist[j] = 7'(cand);
                    m_pred[j] = 5'(i);
                    any = 1;
                end
            end
        end
        if (last) begin
            e_done = 1;
            e_chg = m_changed | any;
            m_count++;
            m_changed = 0;
            if (!e_chg || m_count == 31) begin m_run = 0; m_done = 1; end
        end else begin
            m_changed = m_changed | any;
        end
    endtask

    task automatic do_start(input int src);
        @(posedge clk); #1;
        start = 1; src_idx = 5'(src);
        @(posedge clk); #1;
        start = 0;
        model_start(src);
    endtask

    // Present one beat; for a last beat also wait through its commit edge
    task automatic drive_beat(input logic [21:0] a, b, c, d, input bit last);
        in_valid = 1; lane_a = a; lane_b = b; lane_c = c; lane_d = d; in_last = last;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
        model_beat(a, b, c, d, last);
        if (last) begin @(posedge clk); #1; end
    endtask

    function automatic logic [21:0] rnd_lane();
        int i = $urandom_range(0, 31);
        int sel = $urandom_range(0, 9);
        int wi = (sel < 6) ? int'(m_dist[i]) : (sel < 8) ? $urandom_range(0, 127) : 127;
        return mk($urandom_range(0, 4) != 0, $urandom_range(0, 15), i, $urandom_range(0, 7), wi);
    endfunction

    task automatic test_reset();
        rst = 1; #2;
        model_reset();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b exp 0", in_ready); end
        n_cmp++; if (pass_done !== 1'b0) begin n_err++; $display("FAIL reset_pass_done: got %0b exp 0", pass_done); end
        n_cmp++; if (pass_changed !== 1'b0) begin n_err++; $display("FAIL reset_pass_changed: got %0b exp 0", pass_changed); end
        n_cmp++; if (pass_count !== 5'd0) begin n_err++; $display("FAIL reset_pass_count: got %0d exp 0", pass_count); end
        n_cmp++; if (converged !== 1'b0) begin n_err++; $display("FAIL reset_converged: got %0b exp 0", converged); end
        for (int n = 0; n < 32; n++) begin
            rd_idx = 5'(n); #1;
            n_cmp++; if (rd_dist !== 7'h7F || rd_pred !== 5'd0) begin
                n_err++; $display("FAIL reset_table[%0d]: got %0h/%0d exp 7f/0", n, rd_dist, rd_pred);
            end
        end
        @(posedge clk); #1; rst = 0;
    endtask

    task automatic test_single();
        do_start(0);
        in_valid = 1; lane_a = mk(1, 3, 0, 5, 0); lane_b = '0; lane_c = '0; lane_d = '0; in_last = 1;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
        model_beat(mk(1, 3, 0, 5, 0), '0, '0, '0, 1);
        rd_idx = 5'd5; #1;
        n_cmp++; if (rd_dist !== 7'h7F) begin n_err++; $display("FAIL single_s1_dist5: got %0h exp 7f", rd_dist); end
        @(posedge clk); #1;
        n_cmp++; if (rd_dist !== 7'd3) begin n_err++; $display("FAIL single_dist5: got %0d exp 3", rd_dist); end
        n_cmp++; if (rd_pred !== 5'd0) begin n_err++; $display("FAIL single_pred5: got %0d exp 0", rd_pred); end
        n_cmp++; if (pass_done !== 1'b1) begin n_err++; $display("FAIL single_pass_done: got %0b exp 1", pass_done); end
        n_cmp++; if (pass_changed !== 1'b1) begin n_err++; $display("FAIL single_pass_changed: got %0b exp 1", pass_changed); end
        n_cmp++; if (pass_count !== 5'd1) begin n_err++; $display("FAIL single_pass_count: got %0d exp 1", pass_count); end
        n_cmp++; if (converged !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL single_state: got conv=%0b rdy=%0b exp 0/1", converged, in_ready);
        end
        @(posedge clk); #1;
        n_cmp++; if (pass_done !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %0b exp 0", pass_done); end
    endtask

    task automatic test_same_j();
        do_start(0);
        drive_beat(mk(1, 4, 1, 7, 5), mk(1, 1, 2, 7, 3), '0, '0, 1);
        rd_idx = 5'd7; #1;
        n_cmp++; if (rd_dist !== 7'd4 || rd_pred !== 5'd2) begin
            n_err++; $display("FAIL samej_better_b: got %0d/%0d exp 4/2", rd_dist, rd_pred);
        end
        do_start(0);
        drive_beat(mk(1, 2, 1, 7, 2), mk(1, 1, 2, 7, 3), '0, '0, 1);
        rd_idx = 5'd7; #1;
        n_cmp++; if (rd_dist !== 7'd4 || rd_pred !== 5'd1) begin
            n_err++; $display("FAIL samej_tie: got %0d/%0d exp 4/1", rd_dist, rd_pred);
        end
    endtask

    task automatic test_saturation();
        do_start(0);
        drive_beat(mk(1, 5, 0, 9, 'h7C), mk(1, 0, 0, 10, 'h7F), mk(0, 1, 0, 11, 0), '0, 1);
        n_cmp++; if (pass_done !== 1'b1 || pass_changed !== 1'b0) begin
            n_err++; $display("FAIL sat_pass: got done=%0b chg=%0b exp 1/0", pass_done, pass_changed);
        end
        n_cmp++; if (converged !== 1'b1 || in_ready !== 1'b0 || pass_count !== 5'd1) begin
            n_err++; $display("FAIL sat_state: got conv=%0b rdy=%0b cnt=%0d exp 1/0/1", converged, in_ready, pass_count);
        end
        for (int n = 9; n < 12; n++) begin
            rd_idx = 5'(n); #1;
            n_cmp++; if (rd_dist !== 7'h7F) begin n_err++; $display("FAIL sat_dist[%0d]: got %0h exp 7f", n, rd_dist); end
        end
    endtask

    task automatic test_two_passes();
        do_start(3);
        drive_beat(mk(1, 2, 3, 4, 0), '0, '0, '0, 1);
        n_cmp++; if (pass_done !== 1'b1 || pass_changed !== 1'b1 || pass_count !== 5'd1 || converged !== 1'b0) begin
            n_err++; $display("FAIL two_p1: got done=%0b chg=%0b cnt=%0d conv=%0b exp 1/1/1/0", pass_done, pass_changed, pass_count, converged);
        end
        drive_beat(mk(1, 2, 3, 4, 0), '0, '0, '0, 1);
        n_cmp++; if (pass_done !== 1'b1 || pass_changed !== 1'b0) begin
            n_err++; $display("FAIL two_p2_flags: got done=%0b chg=%0b exp 1/0", pass_done, pass_changed);
        end
        n_cmp++; if (converged !== 1'b1 || in_ready !== 1'b0 || pass_count !== 5'd2) begin
            n_err++; $display("FAIL two_p2_state: got conv=%0b rdy=%0b cnt=%0d exp 1/0/2", converged, in_ready, pass_count);
        end
        drive_beat(mk(1, 0, 3, 4, 0), '0, '0, '0, 1);
        rd_idx = 5'd4; #1;
        n_cmp++; if (rd_dist !== 7'd2 || pass_done !== 1'b0 || pass_count !== 5'd2) begin
            n_err++; $display("FAIL two_dropped: got dist=%0d done=%0b cnt=%0d exp 2/0/2", rd_dist, pass_done, pass_count);
        end
    endtask

    task automatic test_31_passes();
        do_start(0);
        for (int p = 0; p < 31; p++) begin
            drive_beat(mk(1, 1, 0, p + 1, 0), '0, '0, '0, 1);
            n_cmp++; if (pass_count !== 5'(p + 1) || pass_changed !== 1'b1) begin
                n_err++; $display("FAIL p31_count[%0d]: got cnt=%0d chg=%0b exp %0d/1", p, pass_count, pass_changed, p + 1);
            end
            n_cmp++; if (converged !== (p == 30)) begin
                n_err++; $display("FAIL p31_conv[%0d]: got %0b exp %0b", p, converged, p == 30);
            end
        end
    endtask

    task automatic test_start_discard();
        do_start(2);
        in_valid = 1; lane_a = mk(1, 1, 2, 6, 0); lane_b = '0; lane_c = '0; lane_d = '0; in_last = 0;
        @(posedge clk); #1;
        in_valid = 0; start = 1; src_idx = 5'd8;
        @(posedge clk); #1;
        start = 0;
        model_start(8);
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1 || pass_count !== 5'd0) begin
            n_err++; $display("FAIL discard_state: got rdy=%0b cnt=%0d exp 1/0", in_ready, pass_count);
        end
        for (int n = 0; n < 32; n++) begin
            rd_idx = 5'(n); #1;
            n_cmp++; if (rd_dist !== m_dist[n] || rd_pred !== m_pred[n]) begin
                n_err++; $display("FAIL discard_table[%0d]: got %0h/%0d exp %0h/%0d", n, rd_dist, rd_pred, m_dist[n], m_pred[n]);
            end
        end
    endtask

    task automatic test_rst_mid();
        do_start(4);
        drive_beat(mk(1, 1, 4, 5, 0), '0, '0, '0, 1);
        drive_beat(mk(1, 1, 4, 6, 0), '0, '0, '0, 0);
        #1; rst = 1; #1;
        model_reset();
        n_cmp++; if (in_ready !== 1'b0 || pass_done !== 1'b0 || pass_changed !== 1'b0) begin
            n_err++; $display("FAIL rst_flags: got rdy=%0b done=%0b chg=%0b exp 0/0/0", in_ready, pass_done, pass_changed);
        end
        n_cmp++; if (pass_count !== 5'd0 || converged !== 1'b0) begin
            n_err++; $display("FAIL rst_state: got cnt=%0d conv=%0b exp 0/0", pass_count, converged);
        end
        for (int n = 0; n < 32; n++) begin
            rd_idx = 5'(n); #1;
            n_cmp++; if (rd_dist !== 7'h7F || rd_pred !== 5'd0) begin
                n_err++; $display("FAIL rst_table[%0d]: got %0h/%0d exp 7f/0", n, rd_dist, rd_pred);
            end
        end
        @(posedge clk); #1; rst = 0;
        drive_beat(mk(1, 1, 0, 3, 0), '0, '0, '0, 1);
        rd_idx = 5'd3; #1;
        n_cmp++; if (rd_dist !== 7'h7F || pass_done !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_idle_drop: got dist=%0h done=%0b rdy=%0b exp 7f/0/0", rd_dist, pass_done, in_ready);
        end
    endtask

    task automatic test_random();
        int nb;
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        model_reset();
        for (int r = 0; r < 6; r++) begin
            do_start($urandom_range(0, 31));
            for (int p = 0; p < 12; p++) begin
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++) begin
                    drive_beat(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane(), b == nb - 1);
                end
                n_cmp++; if (pass_done !== e_done) begin
                    n_err++; $display("FAIL rand_done[%0d.%0d]: got %0b exp %0b", r, p, pass_done, e_done);
                end
                if (e_done) begin
                    n_cmp++; if (pass_changed !== e_chg) begin
                        n_err++; $display("FAIL rand_changed[%0d.%0d]: got %0b exp %0b", r, p, pass_changed, e_chg);
                    end
                end
                n_cmp++; if (pass_count !== 5'(m_count) || converged !== m_done || in_ready !== m_run) begin
                    n_err++; $display("FAIL rand_state[%0d.%0d]: got cnt=%0d conv=%0b rdy=%0b exp %0d/%0b/%0b",
                                      r, p, pass_count, converged, in_ready, m_count, m_done, m_run);
                end
            end
            for (int n = 0; n < 32; n++) begin
                rd_idx = 5'(n); #1;
                n_cmp++; if (rd_dist !== m_dist[n] || rd_pred !== m_pred[n]) begin
                    n_err++; $display("FAIL rand_table[%0d][%0d]: got %0h/%0d exp %0h/%0d", r, n, rd_dist, rd_pred, m_dist[n], m_pred[n]);
                end
            end
        end
    endtask

    initial begin
        rst = 1; start = 0; src_idx = '0; in_valid = 0; in_last = 0; rd_idx = '0;
        lane_a = '0; lane_b = '0; lane_c = '0; lane_d = '0;
        test_reset();
        test_single();
        test_same_j();
        test_saturation();
        test_two_passes();
        test_31_passes();
        test_start_discard();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
